pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Next-generation fetch PC unit: owns the architectural fetch PC register, selects the next PC from exception, ERET, ID-resolved branch and sequential sources, and adds a parametrised direct-mapped branch target buffer (BTB) for taken-prediction.
- Latches a redirect that arrives while fetch is stalled and applies it when the stall releases.
- Sits between the IF stage (PC output) and the ID and MEM stages (redirect inputs).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_BASE, 32'h0000_0000, exception vector base.
- INT_OFFSET, 32'h0000_0020, offset added to EXC_BASE for an interrupt.
- GEN_OFFSET, 32'h0000_0040, offset added to EXC_BASE for all other causes.
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2; IDX = log2(BTB_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_IF_stall  in  1  hold the current PC.
- i_answer_exc  in  1  MEM takes an exception this cycle.
- i_MEM_exception_cause  in  5  EXC_CAUSE_* code.
- i_MEM_is_eret  in  1  ERET in MEM.
- i_MEM_epc_value  in  32  ERET target.
- i_ID_is_branch_jump_instr  in  1  resolved branch or jump in ID.
- i_ID_taken  in  1  resolved direction.
- i_ID_branch_pc  in  32  PC of the resolved instruction.
- i_ID_branch_jump_dst_pc  in  32  resolved taken target.
- i_ID_fallthrough_pc  in  32  not-taken continuation PC.
- i_ID_pred_taken  in  1  prediction carried from IF for this instruction.
- i_ID_pred_target  in  32  predicted target carried from IF.
- o_IF_pc  out  32  current fetch PC (registered).
- o_IF_pred_taken  out  1  BTB hit on o_IF_pc (combinational).
- o_IF_pred_target  out  32  BTB target on hit, otherwise o_IF_pc+4.
- o_bad_cause  out  1  registered pulse: an exception was taken with an unlisted cause.

Behaviour:
- Reset (asynchronous): o_IF_pc=RESET_PC; all BTB valid bits=0; pending-redirect valid=0; o_bad_cause=0. Reset mid-stall discards any pending redirect.
- Exception vector:
  - EXC_CAUSE_INT gives EXC_BASE+INT_OFFSET.
  - ADEL, ADES, SYS, BP, RI, OV and TRAP give EXC_BASE+GEN_OFFSET.
  - Any other cause gives EXC_BASE+GEN_OFFSET and sets o_bad_cause=1 for one cycle.
- Live redirect classes, in priority order:
  - EXC (3): i_answer_exc.
  - ERET (2): i_MEM_is_eret; target is the EPC value.
  - MISP (1): a resolved branch whose actual outcome differs from its prediction. Mispredict means i_ID_taken != i_ID_pred_taken, or both are taken and i_ID_branch_jump_dst_pc != i_ID_pred_target. Target is the dst PC if taken, otherwise the fallthrough PC.
- A correctly predicted branch generates no redirect.
- Pending register: 32-bit target, 2-bit class, valid bit.
- Cycle with i_IF_stall=1:
  - o_IF_pc holds.
  - A live redirect is stored in pending if pending is invalid, or if the live class is greater than or equal to the pending class.
  - A lower-class live redirect is dropped.
- Cycle with i_IF_stall=0, next PC is the first of:
  1. The live redirect, when its class is greater than or equal to the pending class (or pending is invalid).
  2. The pending target.
  3. o_IF_pred_target (a BTB hit, or PC+4).
- Pending is cleared on every unstalled cycle.
- PC+4 wraps modulo 2^32.
- BTB organisation:
  - Index is pc[IDX+1:2]; tag is pc[31:IDX+2].
  - Each entry holds {valid, tag, target}.
  - Hit means valid and tag equal.
- BTB update, independent of stall, on any cycle with i_ID_is_branch_jump_instr=1:
  - Taken: write {1, tag(branch_pc), dst}.
  - Not taken and the entry's tag matches: clear valid.
  - A lookup in the same cycle sees the old contents; the write is visible next cycle.
- Exceptions and ERET do not touch the BTB.
- Redirect, stall and BTB update in the same cycle are all honoured independently.

Test Plan:
- Reset then run with no stall -> o_IF_pc = 0, 4, 8, 12. Assert reset mid-run -> o_IF_pc=0 immediately, with no clock edge required.
- Taken branch at 0x100 to 0x200, not predicted -> redirect, next PC=0x200, BTB written. Refetch 0x100 -> o_IF_pred_taken=1, target 0x200, and the next PC is 0x200 without redirect.
- Predicted-taken branch at 0x100 resolves not-taken with fallthrough 0x104 -> next PC=0x104; entry invalidated; the following fetch of 0x100 predicts 0x104.
- Stall with MISP (target 0x300) pending, then ERET (EPC 0x500) while stalled, then stall released -> next PC=0x500. With a MISP arriving at release against a pending EXC -> the vector 0x40 is used.
- i_answer_exc with cause INT -> 0x20; cause SYS with simultaneous ERET and branch -> 0x40; cause 5'd31 -> 0x40 and o_bad_cause pulses for one cycle.
- BTB_DEPTH=4 aliasing: 0x100 and 0x110 taken (same index) -> the second overwrites the first; 0x100 then misses. Branch at 0xFFFF_FFFC not predicted -> next PC wraps to 0x0.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: owns the IF program counter, arbitrates exception/ERET/
// mispredict redirects (holding one across a stall) and predicts with a direct-mapped BTB.
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_BASE   = 32'h0000_0000,
    parameter logic [31:0] INT_OFFSET = 32'h0000_0020,
    parameter logic [31:0] GEN_OFFSET = 32'h0000_0040,
    parameter int          BTB_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_IF_stall,
    input  logic        i_answer_exc,
    input  logic [4:0]  i_MEM_exception_cause,
    input  logic        i_MEM_is_eret,
    input  logic [31:0] i_MEM_epc_value,
    input  logic        i_ID_is_branch_jump_instr,
    input  logic        i_ID_taken,
    input  logic [31:0] i_ID_branch_pc,
    input  logic [31:0] i_ID_branch_jump_dst_pc,
    input  logic [31:0] i_ID_fallthrough_pc,
    input  logic        i_ID_pred_taken,
    input  logic [31:0] i_ID_pred_target,
    output logic [31:0] o_IF_pc,
    output logic        o_IF_pred_taken,
    output logic [31:0] o_IF_pred_target,
    output logic        o_bad_cause
);
    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = 30 - IDX;

    localparam logic [4:0] EXC_CAUSE_INT  = 5'd0;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
    localparam logic [4:0] EXC_CAUSE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CAUSE_BP   = 5'd9;
    localparam logic [4:0] EXC_CAUSE_RI   = 5'd10;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;
    localparam logic [4:0] EXC_CAUSE_TRAP = 5'd13;

    // Encoding order is the priority order; CLS_NONE means no live redirect.
    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_MISP = 2'd1,
        CLS_ERET = 2'd2,
        CLS_EXC  = 2'd3
    } redir_cls_t;

    logic             btb_valid  [BTB_DEPTH];
    logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
    logic [31:0]      btb_target [BTB_DEPTH];

    logic [IDX-1:0]   fetch_idx;
    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      pc_plus4;

    logic [31:0]      exc_vector;
    logic             cause_known;
    logic             misp;
    redir_cls_t       live_cls;
    logic [31:0]      live_target;
    logic             take_live;

    logic             pend_valid;
    redir_cls_t       pend_cls;
    logic [31:0]      pend_target;

    assign fetch_idx = o_IF_pc[IDX+1:2];
    assign upd_idx   = i_ID_branch_pc[IDX+1:2];
    assign upd_tag   = i_ID_branch_pc[31:IDX+2];
    assign pc_plus4  = o_IF_pc + 32'd4;

    assign o_IF_pred_taken  = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == o_IF_pc[31:IDX+2]);
    assign o_IF_pred_target = o_IF_pred_taken ? btb_target[fetch_idx] : pc_plus4;

    always_comb begin
        cause_known = 1'b1;
        exc_vector  = EXC_BASE + GEN_OFFSET;
        case (i_MEM_exception_cause)
            EXC_CAUSE_INT:  exc_vector = EXC_BASE + INT_OFFSET;
            EXC_CAUSE_ADEL, EXC_CAUSE_ADES, EXC_CAUSE_SYS, EXC_CAUSE_BP,
            EXC_CAUSE_RI, EXC_CAUSE_OV, EXC_CAUSE_TRAP: cause_known = 1'b1;
            default:        cause_known = 1'b0;
        endcase
    end

    // A taken/taken pair with different targets is still a mispredict.
    assign misp = i_ID_is_branch_jump_instr &&
                  ((i_ID_taken != i_ID_pred_taken) ||
                   (i_ID_taken && (i_ID_branch_jump_dst_pc != i_ID_pred_target)));

    always_comb begin
        live_cls    = CLS_NONE;
        live_target = pc_plus4;
        if (i_answer_exc) begin
            live_cls    = CLS_EXC;
            live_target = exc_vector;
        end else if (i_MEM_is_eret) begin
            live_cls    = CLS_ERET;
            live_target = i_MEM_epc_value;
        end else if (misp) begin
            live_cls    = CLS_MISP;
            live_target = i_ID_taken ? i_ID_branch_jump_dst_pc : i_ID_fallthrough_pc;
        end
    end

    assign take_live = (live_cls != CLS_NONE) && (!pend_valid || (live_cls >= pend_cls));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_IF_pc     <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_cls    <= CLS_NONE;
            pend_target <= 32'd0;
            o_bad_cause <= 1'b0;
        end else begin
            o_bad_cause <= i_answer_exc && !cause_known;
            if (i_IF_stall) begin
                if (take_live) begin
                    pend_valid  <= 1'b1;
                    pend_cls    <= live_cls;
                    pend_target <= live_target;
                end
            end else begin
                pend_valid <= 1'b0;
                if (take_live)       o_IF_pc <= live_target;
                else if (pend_valid) o_IF_pc <= pend_target;
                else                 o_IF_pc <= o_IF_pred_target;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) btb_valid[i] <= 1'b0;
        end else if (i_ID_is_branch_jump_instr) begin
            if (i_ID_taken)                       btb_valid[upd_idx] <= 1'b1;
            else if (btb_tag[upd_idx] == upd_tag) btb_valid[upd_idx] <= 1'b0;
        end
    end

    // Tag/target payload needs no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        if (i_ID_is_branch_jump_instr && i_ID_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= i_ID_branch_jump_dst_pc;
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected PCs are queued as stimulus is driven and
// popped after each rising edge; prediction and bad-cause outputs are checked inline.
module tb_pc_gen;
    logic        clk;
    logic        reset;
    logic        i_IF_stall;
    logic        i_answer_exc;
    logic [4:0]  i_MEM_exception_cause;
    logic        i_MEM_is_eret;
    logic [31:0] i_MEM_epc_value;
    logic        i_ID_is_branch_jump_instr;
    logic        i_ID_taken;
    logic [31:0] i_ID_branch_pc;
    logic [31:0] i_ID_branch_jump_dst_pc;
    logic [31:0] i_ID_fallthrough_pc;
    logic        i_ID_pred_taken;
    logic [31:0] i_ID_pred_target;
    logic [31:0] o_IF_pc;
    logic        o_IF_pred_taken;
    logic [31:0] o_IF_pred_target;
    logic        o_bad_cause;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pc_m;

    pc_gen #(.BTB_DEPTH(4)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_IF_stall                (i_IF_stall),
        .i_answer_exc              (i_answer_exc),
        .i_MEM_exception_cause     (i_MEM_exception_cause),
        .i_MEM_is_eret             (i_MEM_is_eret),
        .i_MEM_epc_value           (i_MEM_epc_value),
        .i_ID_is_branch_jump_instr (i_ID_is_branch_jump_instr),
        .i_ID_taken                (i_ID_taken),
        .i_ID_branch_pc            (i_ID_branch_pc),
        .i_ID_branch_jump_dst_pc   (i_ID_branch_jump_dst_pc),
        .i_ID_fallthrough_pc       (i_ID_fallthrough_pc),
        .i_ID_pred_taken           (i_ID_pred_taken),
        .i_ID_pred_target          (i_ID_pred_target),
        .o_IF_pc                   (o_IF_pc),
        .o_IF_pred_taken           (o_IF_pred_taken),
        .o_IF_pred_target          (o_IF_pred_target),
        .o_bad_cause               (o_bad_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_live();
        i_answer_exc              = 1'b0;
        i_MEM_exception_cause     = 5'd0;
        i_MEM_is_eret             = 1'b0;
        i_MEM_epc_value           = 32'd0;
        i_ID_is_branch_jump_instr = 1'b0;
        i_ID_taken                = 1'b0;
        i_ID_branch_pc            = 32'd0;
        i_ID_branch_jump_dst_pc   = 32'd0;
        i_ID_fallthrough_pc       = 32'd0;
        i_ID_pred_taken           = 1'b0;
        i_ID_pred_target          = 32'd0;
    endtask

    task automatic drive_branch(input logic [31:0] bpc, input logic taken, input logic [31:0] dst,
                                input logic [31:0] fall, input logic ptaken, input logic [31:0] ptgt);
        i_ID_is_branch_jump_instr = 1'b1;
        i_ID_taken                = taken;
        i_ID_branch_pc            = bpc;
        i_ID_branch_jump_dst_pc   = dst;
        i_ID_fallthrough_pc       = fall;
        i_ID_pred_taken           = ptaken;
        i_ID_pred_target          = ptgt;
    endtask

    task automatic drive_eret(input logic [31:0] epc);
        i_MEM_is_eret   = 1'b1;
        i_MEM_epc_value = epc;
    endtask

    task automatic drive_exc(input logic [4:0] cause);
        i_answer_exc          = 1'b1;
        i_MEM_exception_cause = cause;
    endtask

    // Queue the PC expected after the next rising edge, then compare it 1 time unit later.
    task automatic cycle(input string tag, input logic [31:0] next_pc);
        exp_q.push_back(next_pc);
        @(posedge clk);
        #1;
        pc_m = next_pc;
        check(tag, o_IF_pc, exp_q.pop_front());
    endtask

    initial begin
        reset      = 1'b1;
        i_IF_stall = 1'b0;
        pc_m       = 32'd0;
        clear_live();
        #3;
        check("reset_pc", o_IF_pc, 32'd0);
        check("reset_pred", {31'd0, o_IF_pred_taken}, 32'd0);
        check("reset_bad", {31'd0, o_bad_cause}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // sequential fetch and asynchronous reset
        check("seq0", o_IF_pc, 32'd0);
        cycle("seq4", 32'd4);
        cycle("seq8", 32'd8);
        cycle("seq12", 32'd12);
        check("seq_pred_tgt", o_IF_pred_target, 32'd16);
        reset = 1'b1;
        #1;
        check("async_reset", o_IF_pc, 32'd0);
        reset = 1'b0;
        cycle("after_reset", 32'd4);

        // taken branch, not predicted, then predicted on refetch
        drive_branch(32'h100, 1'b1, 32'h200, 32'h104, 1'b0, 32'h104);
        cycle("misp_taken", 32'h200);
        clear_live();
        drive_eret(32'h100);
        cycle("eret_to_100", 32'h100);
        clear_live();
        check("btb_hit", {31'd0, o_IF_pred_taken}, 32'd1);
        check("btb_tgt", o_IF_pred_target, 32'h200);
        cycle("pred_follow", 32'h200);
        drive_branch(32'h100, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
        cycle("correct_pred_no_redir", 32'h204);
        clear_live();

        // predicted taken resolves not taken
        drive_eret(32'h100);
        cycle("eret_to_100b", 32'h100);
        clear_live();
        check("btb_hit2", {31'd0, o_IF_pred_taken}, 32'd1);
        cycle("pred_follow2", 32'h200);
        drive_branch(32'h100, 1'b0, 32'h200, 32'h104, 1'b1, 32'h200);
        cycle("misp_not_taken", 32'h104);
        clear_live();
        drive_eret(32'h100);
        cycle("eret_to_100c", 32'h100);
        clear_live();
        check("btb_invalidated", {31'd0, o_IF_pred_taken}, 32'd0);
        check("btb_inval_tgt", o_IF_pred_target, 32'h104);

        // same-cycle update is not visible to the lookup
        drive_branch(32'h100, 1'b1, 32'h200, 32'h104, 1'b1, 32'h200);
        check("same_cycle_old", {31'd0, o_IF_pred_taken}, 32'd0);
        cycle("same_cycle_seq", 32'h104);
        clear_live();
        drive_eret(32'h100);
        cycle("eret_to_100d", 32'h100);
        clear_live();
        check("write_visible", {31'd0, o_IF_pred_taken}, 32'd1);
        cycle("pred_follow3", 32'h200);

        // stall: MISP pending upgraded by ERET
        i_IF_stall = 1'b1;
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("stall_hold1", 32'h200);
        clear_live();
        drive_eret(32'h500);
        cycle("stall_hold2", 32'h200);
        clear_live();
        cycle("stall_hold3", 32'h200);
        i_IF_stall = 1'b0;
        cycle("release_eret", 32'h500);

        // lower class dropped while stalled
        i_IF_stall = 1'b1;
        drive_eret(32'h600);
        cycle("stall_hold4", 32'h500);
        clear_live();
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("stall_hold5", 32'h500);
        clear_live();
        i_IF_stall = 1'b0;
        cycle("lower_dropped", 32'h600);

        // equal class replaces pending
        i_IF_stall = 1'b1;
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("stall_hold6", 32'h600);
        drive_branch(32'h180, 1'b1, 32'h340, 32'h184, 1'b0, 32'h184);
        cycle("stall_hold7", 32'h600);
        clear_live();
        i_IF_stall = 1'b0;
        cycle("equal_replaces", 32'h340);

        // higher live class at release beats pending
        i_IF_stall = 1'b1;
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("stall_hold8", 32'h340);
        clear_live();
        i_IF_stall = 1'b0;
        drive_eret(32'h700);
        cycle("live_beats_pending", 32'h700);
        clear_live();

        // pending EXC beats MISP arriving at release
        i_IF_stall = 1'b1;
        drive_exc(5'd8);
        cycle("stall_hold9", 32'h700);
        clear_live();
        i_IF_stall = 1'b0;
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("pending_exc_wins", 32'h40);
        clear_live();
        check("sys_not_bad", {31'd0, o_bad_cause}, 32'd0);

        // exception vectors and priority
        drive_exc(5'd0);
        cycle("exc_int", 32'h20);
        clear_live();
        drive_exc(5'd8);
        drive_eret(32'h500);
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("exc_priority", 32'h40);
        clear_live();
        drive_exc(5'd31);
        cycle("exc_bad", 32'h40);
        clear_live();
        check("bad_pulse", {31'd0, o_bad_cause}, 32'd1);
        cycle("after_bad", 32'h44);
        check("bad_cleared", {31'd0, o_bad_cause}, 32'd0);

        // aliasing in a 4-entry BTB
        drive_branch(32'h100, 1'b1, 32'h200, 32'h104, 1'b0, 32'h104);
        cycle("alias_a", 32'h200);
        drive_branch(32'h110, 1'b1, 32'h280, 32'h114, 1'b0, 32'h114);
        cycle("alias_b", 32'h280);
        clear_live();
        drive_eret(32'h110);
        cycle("eret_to_110", 32'h110);
        clear_live();
        check("alias_hit", {31'd0, o_IF_pred_taken}, 32'd1);
        check("alias_tgt", o_IF_pred_target, 32'h280);
        drive_eret(32'h100);
        cycle("eret_to_100e", 32'h100);
        clear_live();
        check("alias_evicted", {31'd0, o_IF_pred_taken}, 32'd0);
        check("alias_evicted_tgt", o_IF_pred_target, 32'h104);

        // wrap of PC+4
        drive_eret(32'hFFFF_FFFC);
        cycle("eret_to_top", 32'hFFFF_FFFC);
        clear_live();
        check("wrap_tgt", o_IF_pred_target, 32'd0);
        cycle("wrap", pc_m + 32'd4);

        // reset mid-stall discards pending
        i_IF_stall = 1'b1;
        drive_branch(32'h180, 1'b1, 32'h300, 32'h184, 1'b0, 32'h184);
        cycle("stall_hold10", 32'd0);
        clear_live();
        reset = 1'b1;
        #1;
        check("reset_mid_stall", o_IF_pc, 32'd0);
        reset = 1'b0;
        i_IF_stall = 1'b0;
        cycle("pending_discarded", 32'd4);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
